// File: rtl/video_to_axis_if.sv
// ---------------------------------------------------------------------------
// video_to_axis_if
//   AXI4-Stream video bus carrying one pixel per beat.
//   tdata  : pixel
//   tvalid : beat valid
//   tready : sink ready
//   tuser  : first pixel of a frame (SOF)
//   tlast  : last pixel of a line (EOL)
//   Modports: master (stream source), slave (stream sink).
// ---------------------------------------------------------------------------
interface video_to_axis_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tdata, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/video_to_axis.sv
// ---------------------------------------------------------------------------
// video_to_axis
//   Converts parallel RGB video (data/de/hsync/vsync) into an AXI4-Stream
//   video stream (tuser = start of frame, tlast = end of line). A first-word
//   fall-through FIFO absorbs downstream backpressure; when a pixel cannot be
//   stored the rest of that frame is discarded and the stream resumes on the
//   next frame, so the output always begins on a complete frame.
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   video_data/de       : pixel and active-video enable
//   video_hsync/vsync   : syncs, active-high (vsync rising edge = new frame)
//   m_axis              : stream output (video_to_axis_if.master)
//   overflow            : sticky, a pixel was dropped since reset
//   hactive_measured    : DE pixels in the last complete line
//   vactive_measured    : DE lines in the last frame
//
// Optional feature macro: VIDEO_TO_AXIS_MEASURE_EN
//   defined   : line/frame measurement counters are built
//   undefined : hactive_measured / vactive_measured tie to zero
// ---------------------------------------------------------------------------
module video_to_axis #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 2048,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  video_data,
  input  logic                   video_de,
  input  logic                   video_hsync,
  input  logic                   video_vsync,
  video_to_axis_if.master        m_axis,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] hactive_measured,
  output logic [COUNT_WIDTH-1:0] vactive_measured
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    DROP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // hsync only matters for timing sources; line boundaries come from de
  logic w_unused_hsync;
  assign w_unused_hsync = video_hsync;

  // -------------------------------------------------------------------------
  // Stage 1: input registers and SOF detection
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_de;
  logic                  r_vsync;
  logic                  r_vsync_prev;
  logic                  w_sof;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data       <= '0;
      r_de         <= 1'b0;
      r_vsync      <= 1'b0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_data       <= video_data;
      r_de         <= video_de;
      r_vsync      <= video_vsync;
      r_vsync_prev <= r_vsync;
    end
  end

  assign w_sof = r_vsync & ~r_vsync_prev;

  // -------------------------------------------------------------------------
  // Stage 2: one-pixel hold. The held pixel is emitted in the cycle after it
  // was captured, when stage 1 tells whether the line continues, so tlast can
  // be decided without lookahead on the video inputs.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_valid;
  logic                  r_hold_user;
  logic                  r_first;
  logic                  w_hold_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_hold_user  <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_hold_valid <= r_de;
      if (r_de) begin
        r_hold_data <= r_data;
        r_hold_user <= w_sof | r_first;
      end
      // r_first marks "SOF seen, first pixel not yet captured"
      if (w_sof) begin
        r_first <= ~r_de;
      end else if (r_de) begin
        r_first <= 1'b0;
      end
    end
  end

  // held pixel ends its line when no pixel follows or a new frame starts
  assign w_hold_last = ~r_de | w_sof;

  // -------------------------------------------------------------------------
  // FIFO bookkeeping
  // -------------------------------------------------------------------------
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_drop;
  logic [EW-1:0] w_rd_entry;

  assign w_full  = (r_count == FULL_C);
  assign w_empty = (r_count == '0);
  assign w_rd_en = ~w_empty & m_axis.tready;

  // -------------------------------------------------------------------------
  // Frame admission FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= WAIT_SOF;
      overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      WAIT_SOF: begin
        if (w_sof) begin
          w_state_next = PASS;
        end
      end
      PASS: begin
        // fullness is judged at cycle start; a same-cycle read frees nothing
        if (r_hold_valid) begin
          if (w_full) begin
            w_drop       = 1'b1;
            w_state_next = DROP;
          end else begin
            w_wr_en = 1'b1;
          end
        end
      end
      DROP: begin
        if (w_sof) begin
          w_state_next = PASS;
        end
      end
      default: begin
        w_state_next = WAIT_SOF;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_hold_user, w_hold_last, r_hold_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + CW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + CW'(1);
      end
      unique case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Fall-through output; masked to zero while empty so stale memory never
  // shows on the bus (in particular right after reset).
  assign w_rd_entry    = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis.tvalid = ~w_empty;
  assign m_axis.tdata  = w_empty ? '0   : w_rd_entry[DATA_WIDTH-1:0];
  assign m_axis.tlast  = w_empty ? 1'b0 : w_rd_entry[DATA_WIDTH];
  assign m_axis.tuser  = w_empty ? 1'b0 : w_rd_entry[DATA_WIDTH+1];

  // -------------------------------------------------------------------------
  // Optional measurement, independent of FSM state and overflow
  // -------------------------------------------------------------------------
`ifdef VIDEO_TO_AXIS_MEASURE_EN
  logic                   r_de_prev;
  logic [COUNT_WIDTH-1:0] r_pix_cnt;
  logic [COUNT_WIDTH-1:0] r_line_cnt;
  logic [COUNT_WIDTH-1:0] r_hactive;
  logic [COUNT_WIDTH-1:0] r_vactive;
  logic                   w_de_rise;

  assign w_de_rise = r_de & ~r_de_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_de_prev  <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_hactive  <= '0;
      r_vactive  <= '0;
    end else begin
      r_de_prev <= r_de;

      if (r_de) begin
        if (r_pix_cnt != '1) begin
          r_pix_cnt <= r_pix_cnt + COUNT_WIDTH'(1);
        end
      end else if (r_de_prev) begin
        r_hactive <= r_pix_cnt;
        r_pix_cnt <= '0;
      end

      // a line starting in the SOF cycle belongs to the new frame
      if (w_sof) begin
        r_vactive  <= r_line_cnt;
        r_line_cnt <= w_de_rise ? COUNT_WIDTH'(1) : '0;
      end else if (w_de_rise && (r_line_cnt != '1)) begin
        r_line_cnt <= r_line_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign hactive_measured = r_hactive;
  assign vactive_measured = r_vactive;
`else
  assign hactive_measured = '0;
  assign vactive_measured = '0;
`endif

endmodule

// File: tb/tb_video_to_axis.sv
// ---------------------------------------------------------------------------
// tb_video_to_axis
//   Two instances share one video source: u_dut_a (FIFO_DEPTH=64) and
//   u_dut_b (FIFO_DEPTH=16). Expected beats are built per frame from the
//   stream rules (tuser on the first pixel of a frame, tlast on the last
//   pixel of each line, pixel order preserved) and kept in one queue per
//   instance; a negedge monitor pops and compares each accepted beat.
//   Pixel data = {frame id, line, pixel}.
// ---------------------------------------------------------------------------
module tb_video_to_axis;

  localparam int DW     = 24;
  localparam int CNTW   = 16;
  localparam int HACT   = 8;
  localparam int VACT   = 4;
  localparam int HBLANK = 4;
  localparam int DEPTH_B = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] video_data;
  logic          video_de;
  logic          video_hsync;
  logic          video_vsync;
  logic          overflow_a, overflow_b;
  logic [CNTW-1:0] hact_a, vact_a, hact_b, vact_b;

  video_to_axis_if #(.DATA_WIDTH(DW)) axis_a ();
  video_to_axis_if #(.DATA_WIDTH(DW)) axis_b ();

  video_to_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(64), .COUNT_WIDTH(CNTW)) u_dut_a (
    .clock            (clock),
    .reset            (reset),
    .video_data       (video_data),
    .video_de         (video_de),
    .video_hsync      (video_hsync),
    .video_vsync      (video_vsync),
    .m_axis           (axis_a),
    .overflow         (overflow_a),
    .hactive_measured (hact_a),
    .vactive_measured (vact_a)
  );

  video_to_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH_B), .COUNT_WIDTH(CNTW)) u_dut_b (
    .clock            (clock),
    .reset            (reset),
    .video_data       (video_data),
    .video_de         (video_de),
    .video_hsync      (video_hsync),
    .video_vsync      (video_vsync),
    .m_axis           (axis_b),
    .overflow         (overflow_b),
    .hactive_measured (hact_b),
    .vactive_measured (vact_b)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW+1:0] q_a[$];
  logic [DW+1:0] q_b[$];

  // 0 = hold low, 1 = hold high, 2 = random 50%
  int mode_a = 1;
  int mode_b = 1;

`ifdef VIDEO_TO_AXIS_MEASURE_EN
  localparam logic [CNTW-1:0] EXP_HACT = CNTW'(HACT);
  localparam logic [CNTW-1:0] EXP_VACT = CNTW'(VACT);
`else
  localparam logic [CNTW-1:0] EXP_HACT = '0;
  localparam logic [CNTW-1:0] EXP_VACT = '0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ready generators
  initial begin
    axis_a.tready = 1'b1;
    axis_b.tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      axis_a.tready = (mode_a == 2) ? ($urandom_range(0, 1) == 1) : (mode_a == 1);
      axis_b.tready = (mode_b == 2) ? ($urandom_range(0, 1) == 1) : (mode_b == 1);
    end
  end

  // beat scoreboards
  always @(negedge clock) begin
    if (!reset && axis_a.tvalid && axis_a.tready) begin
      if (q_a.size() == 0) check_eq("a_extra_beat", 64'(axis_a.tvalid), 64'd0);
      else check_eq("a_beat", 64'({axis_a.tuser, axis_a.tlast, axis_a.tdata}), 64'(q_a.pop_front()));
    end
    if (!reset && axis_b.tvalid && axis_b.tready) begin
      if (q_b.size() == 0) check_eq("b_extra_beat", 64'(axis_b.tvalid), 64'd0);
      else check_eq("b_beat", 64'({axis_b.tuser, axis_b.tlast, axis_b.tdata}), 64'(q_b.pop_front()));
    end
  end

  // stall stability on instance a
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_beat  = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("a_stall_valid", 64'(axis_a.tvalid), 64'd1);
        check_eq("a_stall_beat", 64'({axis_a.tuser, axis_a.tlast, axis_a.tdata}), 64'(prev_beat));
      end
      prev_stall <= axis_a.tvalid && !axis_a.tready;
      prev_beat  <= {axis_a.tuser, axis_a.tlast, axis_a.tdata};
    end
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [DW-1:0] d);
    video_de    = de;
    video_hsync = hs;
    video_vsync = vs;
    video_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic send_vsync();
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Drives nl lines of np pixels. exp_a: instance a admits this frame.
  // lim_b: how many of this frame's pixels instance b keeps.
  // A synchronous reset is applied in place of pixel (rl, rp) when rl >= 0.
  task automatic send_lines(input int fid, input int nl, input int np, input bit exp_a,
                            input int lim_b, input int rl, input int rp);
    int kept_b = 0;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        logic [DW+1:0] beat;
        beat = {(l == 0 && p == 0), (p == np - 1), 8'(fid), 8'(l), 8'(p)};
        if (exp_a) q_a.push_back(beat);
        if (kept_b < lim_b) begin
          q_b.push_back(beat);
          kept_b++;
        end
      end
    end
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        if (l == rl && p == rp) begin
          reset = 1'b1;
          drive(1'b1, 1'b0, 1'b0, {8'(fid), 8'(l), 8'(p)});
          check_eq("rst_tvalid_a", 64'(axis_a.tvalid), 64'd0);
          check_eq("rst_tvalid_b", 64'(axis_b.tvalid), 64'd0);
          check_eq("rst_overflow_b", 64'(overflow_b), 64'd0);
          check_eq("rst_tdata_a", 64'(axis_a.tdata), 64'd0);
          q_a.delete();
          q_b.delete();
          reset = 1'b0;
        end else begin
          drive(1'b1, 1'b0, 1'b0, {8'(fid), 8'(l), 8'(p)});
        end
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b0, '0);
      repeat (HBLANK - 2) drive(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (4) @(posedge clock);
    #1;
    check_eq({tag, "_drain_a"}, 64'(q_a.size()), 64'd0);
    check_eq({tag, "_drain_b"}, 64'(q_b.size()), 64'd0);
    check_eq({tag, "_idle_a"}, 64'(axis_a.tvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    video_data  = '0;
    video_de    = 1'b0;
    video_hsync = 1'b0;
    video_vsync = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_tvalid", 64'(axis_a.tvalid), 64'd0);
    check_eq("reset_tdata", 64'(axis_a.tdata), 64'd0);
    check_eq("reset_tuser", 64'(axis_a.tuser), 64'd0);
    check_eq("reset_tlast", 64'(axis_a.tlast), 64'd0);
    check_eq("reset_overflow", 64'(overflow_a), 64'd0);
    check_eq("reset_hact", 64'(hact_a), 64'd0);
    check_eq("reset_vact", 64'(vact_a), 64'd0);
    reset = 1'b0;

    // 1: start mid-frame, then one full frame
    send_lines(0, 2, HACT, 1'b0, 0, -1, -1);
    check_eq("midframe_no_beat", 64'(axis_a.tvalid), 64'd0);
    send_vsync();
    send_lines(1, VACT, HACT, 1'b1, 1000, -1, -1);
    wait_drain("t1");
    check_eq("t1_overflow_a", 64'(overflow_a), 64'd0);
    check_eq("t1_overflow_b", 64'(overflow_b), 64'd0);

    // 2: instance b stalled for one frame overflows, recovers on next frame
    mode_b = 0;
    send_vsync();
    send_lines(2, VACT, HACT, 1'b1, DEPTH_B, -1, -1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
    check_eq("t2_overflow_b", 64'(overflow_b), 64'd1);
    check_eq("t2_overflow_a", 64'(overflow_a), 64'd0);
    check_eq("t2_held_b", 64'(axis_b.tvalid), 64'd1);
    mode_b = 1;
    send_vsync();
    send_lines(3, VACT, HACT, 1'b1, 1000, -1, -1);
    wait_drain("t2");
    check_eq("t2_overflow_sticky", 64'(overflow_b), 64'd1);

    // 3: random backpressure on instance a, five frames
    mode_a = 2;
    for (int f = 0; f < 5; f++) begin
      send_vsync();
      send_lines(4 + f, VACT, HACT, 1'b1, 1000, -1, -1);
    end
    mode_a = 1;
    wait_drain("t3");
    check_eq("t3_overflow_a", 64'(overflow_a), 64'd0);

    // 4: reset in the middle of the second line, then a full frame
    send_vsync();
    send_lines(9, VACT, HACT, 1'b1, 1000, 1, 3);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
    check_eq("t4_overflow_a", 64'(overflow_a), 64'd0);
    check_eq("t4_wait_sof", 64'(axis_a.tvalid), 64'd0);
    send_vsync();
    send_lines(10, VACT, HACT, 1'b1, 1000, -1, -1);
    wait_drain("t4");

    // 5: single-pixel frame, also checks three-cycle latency
    send_vsync();
    q_a.push_back({1'b1, 1'b1, 8'd11, 8'd0, 8'd0});
    q_b.push_back({1'b1, 1'b1, 8'd11, 8'd0, 8'd0});
    drive(1'b1, 1'b0, 1'b0, {8'd11, 8'd0, 8'd0});
    drive(1'b0, 1'b0, 1'b0, '0);
    check_eq("t5_latency_early", 64'(axis_a.tvalid), 64'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    check_eq("t5_latency_valid", 64'(axis_a.tvalid), 64'd1);
    wait_drain("t5");

    // 6: measurement after the second vsync rise of full frames
    send_vsync();
    send_lines(12, VACT, HACT, 1'b1, 1000, -1, -1);
    send_vsync();
    check_eq("t6_hact_a", 64'(hact_a), 64'(EXP_HACT));
    check_eq("t6_vact_a", 64'(vact_a), 64'(EXP_VACT));
    check_eq("t6_hact_b", 64'(hact_b), 64'(EXP_HACT));
    check_eq("t6_vact_b", 64'(vact_b), 64'(EXP_VACT));
    send_lines(13, VACT, HACT, 1'b1, 1000, -1, -1);
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
